// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: instruction in, extended immediate out.
interface imm_extend_pipe_if #(
    parameter int IW  = 8,
    parameter int OPW = 3,
    parameter int DW  = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [IW-1:0]  instr;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  imm;
    logic [OPW-1:0] op_out;
    logic           imm_signed;
    logic           prefix_pending;

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, imm, op_out, imm_signed, prefix_pending
    );

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, imm, op_out, imm_signed, prefix_pending
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered immediate extractor: splits opcode/field, sign- or zero-extends per opcode.
// Define IMM_PREFIX_EN to build the prefix FSM that forms double-width immediates.
module imm_extend_pipe #(
    parameter int             IW          = 8,
    parameter int             OPW         = 3,
    parameter int             DW          = 16,
    parameter logic [(1<<OPW)-1:0] SIGNED_MASK = 8'b0001_1000,
    parameter logic [OPW-1:0] PREFIX_OP   = 3'd7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    imm_extend_pipe_if.slave bus
);
    localparam int FW = IW - OPW;

`ifdef IMM_PREFIX_EN
    localparam logic PREFIX_EN = 1'b1;
`else
    localparam logic PREFIX_EN = 1'b0;
`endif

    function automatic logic [DW-1:0] extend_single(input logic [FW-1:0] f, input logic sgn);
        return {{(DW-FW){sgn & f[FW-1]}}, f};
    endfunction

    function automatic logic [DW-1:0] extend_double(input logic [2*FW-1:0] v, input logic sgn);
        return {{(DW-2*FW){sgn & v[2*FW-1]}}, v};
    endfunction

    logic [FW-1:0]  field;
    logic [OPW-1:0] op;
    logic           op_signed;
    logic           accept;
    logic           is_pfx;
    logic           emit;
    logic           pfx_active;
    logic [FW-1:0]  pfx_val;

    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  imm_q, imm_d;
    logic [OPW-1:0] op_q, op_d;
    logic           imm_signed_q, imm_signed_d;

    assign field     = bus.instr[FW-1:0];
    assign op        = bus.instr[IW-1:FW];
    assign op_signed = SIGNED_MASK[op];

    // in_ready depends only on the output register and the consumer
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_pfx       = PREFIX_EN && (op == PREFIX_OP);
    assign emit         = accept && !is_pfx;

`ifdef IMM_PREFIX_EN
    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] pfx_q, pfx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pfx_q   <= '0;
        end else begin
            state_q <= state_d;
            pfx_q   <= pfx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pfx_d   = pfx_q;
        if (flush) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = is_pfx ? PEND : IDLE;
            if (is_pfx) pfx_d = field;
        end
    end

    always_comb begin
        pfx_active = (state_q == PEND);
        pfx_val    = pfx_q;
    end
`else
    assign pfx_active = 1'b0;
    assign pfx_val    = '0;
`endif

    assign bus.prefix_pending = pfx_active;

    always_comb begin
        out_valid_d  = out_valid_q;
        imm_d        = imm_q;
        op_d         = op_q;
        imm_signed_d = imm_signed_q;
        // flush wins over both a new accept and the consumer draining the output
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (emit) begin
            out_valid_d  = 1'b1;
            op_d         = op;
            imm_signed_d = op_signed;
            imm_d        = pfx_active ? extend_double({pfx_val, field}, op_signed)
                                      : extend_single(field, op_signed);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            imm_q        <= '0;
            op_q         <= '0;
            imm_signed_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            imm_q        <= imm_d;
            op_q         <= op_d;
            imm_signed_q <= imm_signed_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.imm        = imm_q;
    assign bus.op_out     = op_q;
    assign bus.imm_signed = imm_signed_q;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: directed scenarios plus randomized traffic.
module tb_imm_extend_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    imm_extend_pipe_if #(.IW(8), .OPW(3), .DW(16)) bus ();

    imm_extend_pipe #(
        .IW(8), .OPW(3), .DW(16),
        .SIGNED_MASK(8'b0001_1000),
        .PREFIX_OP(3'd7)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus(bus)
    );

`ifdef IMM_PREFIX_EN
    localparam bit PFX_EN = 1'b1;
`else
    localparam bit PFX_EN = 1'b0;
`endif
    localparam logic [7:0] MASK = 8'b0001_1000;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] imm;
        logic        sgn;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   model_pend = 1'b0;
    int   model_pfx  = 0;
    bit   rst_event  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: value of the (possibly prefixed) field, reinterpreted as negative when signed.
    function automatic exp_t model(input int op, input int f);
        exp_t e;
        int   w;
        int   v;
        w = model_pend ? 10 : 5;
        v = model_pend ? (model_pfx * 32 + f) : f;
        if (MASK[op] && v >= (1 << (w - 1))) v = v - (1 << w);
        e.op  = 3'(op);
        e.imm = 16'(v);
        e.sgn = MASK[op];
        return e;
    endfunction

    task automatic cyc(input logic v, input logic [7:0] ins, input logic ordy, input logic fl);
        int   op;
        int   f;
        logic exp_rdy;
        @(posedge clk);
        #2;
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.out_ready = ordy;
        flush         = fl;
        @(negedge clk);
        exp_rdy = !bus.out_valid || ordy;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("prefix_pending", 32'(bus.prefix_pending), 32'(model_pend));
        if (fl) begin
            q.delete();
            model_pend = 1'b0;
        end else if (v && exp_rdy) begin
            op = int'(ins[7:5]);
            f  = int'(ins[4:0]);
            if (PFX_EN && op == 7) begin
                model_pend = 1'b1;
                model_pfx  = f;
            end else begin
                q.push_back(model(op, f));
                model_pend = 1'b0;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_imm"}, 32'(bus.imm), 32'd0);
        chk({tag, "_op_out"}, 32'(bus.op_out), 32'd0);
        chk({tag, "_imm_signed"}, 32'(bus.imm_signed), 32'd0);
        chk({tag, "_prefix_pending"}, 32'(bus.prefix_pending), 32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        rst_n        = 1'b0;
        #1;
        check_reset_state("async_rst");
        q.delete();
        model_pend = 1'b0;
        rst_event  = 1'b1;
        #1 rst_n = 1'b1;
    endtask

    // Monitor: pops on every output handshake and checks stability under backpressure.
    exp_t prev;
    bit   prev_stall = 1'b0;
    bit   prev_flush = 1'b0;

    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        cur = {bus.op_out, bus.imm, bus.imm_signed};
        if (rst_n) begin
            if (prev_stall && !prev_flush && !rst_event) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_data", 32'(cur), 32'(prev));
            end
            if (bus.out_valid && bus.out_ready && !flush) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got op=%0d imm=%0h with no expected entry",
                             bus.op_out, bus.imm);
                end else begin
                    e = q.pop_front();
                    chk("output", 32'(cur), 32'(e));
                end
            end
        end
        prev       = cur;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_flush = flush;
        rst_event  = 1'b0;
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Signed addi, zero-extended load, signed beq
        cyc(1'b1, 8'b011_11000, 1'b1, 1'b0);
        cyc(1'b1, 8'b000_11111, 1'b1, 1'b0);
        chk("addi_imm", 32'(bus.imm), 32'h0000_FFF8);
        chk("addi_op", 32'(bus.op_out), 32'd3);
        chk("addi_signed", 32'(bus.imm_signed), 32'd1);
        cyc(1'b1, 8'b100_10000, 1'b1, 1'b0);
        chk("load_imm", 32'(bus.imm), 32'h0000_001F);
        chk("load_signed", 32'(bus.imm_signed), 32'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("beq_imm", 32'(bus.imm), 32'h0000_FFF0);

        // Backpressure: second instruction waits until the consumer is ready
        cyc(1'b1, 8'b010_00001, 1'b0, 1'b0);
        cyc(1'b1, 8'b011_00010, 1'b0, 1'b0);
        chk("bp_imm_first", 32'(bus.imm), 32'h0000_0001);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        cyc(1'b1, 8'b011_00010, 1'b0, 1'b0);
        cyc(1'b1, 8'b011_00010, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp_imm_second", 32'(bus.imm), 32'h0000_0002);
        chk("bp_op_second", 32'(bus.op_out), 32'd3);

`ifdef IMM_PREFIX_EN
        cyc(1'b1, 8'b111_10101, 1'b1, 1'b0);
        cyc(1'b1, 8'b011_00011, 1'b1, 1'b0);
        chk("pfx_pending", 32'(bus.prefix_pending), 32'd1);
        chk("pfx_no_output", 32'(bus.out_valid), 32'd0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pfx_imm", 32'(bus.imm), 32'h0000_FEA3);
        chk("pfx_op", 32'(bus.op_out), 32'd3);
`else
        cyc(1'b1, 8'b111_10101, 1'b1, 1'b0);
        cyc(1'b1, 8'b011_00011, 1'b1, 1'b0);
        chk("op7_op", 32'(bus.op_out), 32'd7);
        chk("op7_imm", 32'(bus.imm), 32'h0000_0015);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("op3_op", 32'(bus.op_out), 32'd3);
        chk("op3_imm", 32'(bus.imm), 32'h0000_0003);
`endif

        // Asynchronous reset while an output is stalled, and while a prefix is stored
        cyc(1'b1, 8'b010_00101, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        pulse_reset();
        cyc(1'b1, 8'b111_00110, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        pulse_reset();

        // Flush with a valid input in the same cycle: output and input both dropped
        cyc(1'b1, 8'b010_00011, 1'b0, 1'b0);
        cyc(1'b1, 8'b011_00111, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        cyc(1'b1, 8'b111_00001, 1'b1, 1'b0);
        cyc(1'b1, 8'b011_00010, 1'b1, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_pending", 32'(bus.prefix_pending), 32'd0);
        chk("flush_out_valid2", 32'(bus.out_valid), 32'd0);
        cyc(1'b1, 8'b011_00001, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_flush_imm", 32'(bus.imm), 32'h0000_0001);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 31) == 0));
        end

        repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Registered, parametrised immediate extractor for the nRISC instruction path, and the successor to the combinational 8-bit sign extender. It takes one instruction per handshake and splits off the opcode and the low immediate field. It sign- or zero-extends that field to the datapath width according to a per-opcode mask and returns the result one cycle later on a valid/ready interface. An optional prefix mechanism builds double-width immediates from two consecutive instructions.

## Interface
- IW, 8: instruction width.
- OPW, 3: opcode width. The opcode is instr[IW-1:IW-OPW]. The field width is FW = IW-OPW.
- DW, 16: output immediate width. DW >= 2*FW is required.
- SIGNED_MASK, 8'b0001_1000: 2^OPW bits. Bit k=1 means opcode k is sign-extended; bit k=0 means zero-extended. The default gives addi (3) and beq (4) signed.
- PREFIX_OP, 3'd7: opcode treated as an immediate prefix (used only with IMM_PREFIX_EN).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, active-low, asynchronous.
- flush  in  1  synchronous clear of the pipeline and of any pending prefix.
- in_valid  in  1  instruction present.
- in_ready  out  1  block accepts the instruction this cycle.
- instr  in  IW  instruction word.
- out_valid  out  1  imm/op_out hold a result.
- out_ready  in  1  consumer takes the result.
- imm  out  DW  extended immediate.
- op_out  out  OPW  opcode of the emitted instruction.
- imm_signed  out  1  1 if imm was sign-extended.
- prefix_pending  out  1  a prefix field is stored (always 0 without IMM_PREFIX_EN).

## Operation
- in_ready = !out_valid || out_ready. An input is accepted when in_valid && in_ready.
- Field: f = instr[FW-1:0] and op = instr[IW-1:IW-OPW].
- Normal accept:
  - Output register loads op_out=op and imm_signed=SIGNED_MASK[op].
  - imm = f extended to DW: sign-extended if SIGNED_MASK[op], otherwise zero-extended.
  - out_valid=1.
- Output hold: while out_valid && !out_ready, all outputs stay stable.
- Output release: if out_ready=1 and no new accept occurs in that cycle, out_valid clears.
- Accept while draining: an accept in the same cycle as out_ready replaces the output register, so out_valid stays 1 and there is no bubble.
- Prefix state machine, two states:
  - IDLE → PEND: accepting op==PREFIX_OP stores f in pfx. No output is produced.
  - PEND → PEND: a further prefix overwrites pfx. Prefixes do not chain.
  - PEND → IDLE: accepting a non-prefix instruction emits imm = {pfx, f} (2*FW bits), extended to DW using bit 2*FW-1 as the sign when SIGNED_MASK[op].
- A prefix obeys the same in_ready rule as other instructions.
- flush=1:
  - Next edge: out_valid=0 and state=IDLE.
  - Any input accepted in the flush cycle is discarded. in_ready still follows its normal rule.
  - flush takes priority over accept and over out_ready.

## Timing
- Latency: 1 cycle from accept to out_valid. Throughput: 1 per cycle while out_ready=1.
- Reset (rst_n low, asynchronous, at any time, including mid-prefix or mid-stall):
  - out_valid=0, imm=0, op_out=0, imm_signed=0, prefix_pending=0, state IDLE.
  - in_ready=1 during and after reset.
- The first accept is possible on the first rising edge after rst_n deasserts.
- in_ready is combinational from out_valid and out_ready only. No other input-to-output combinational paths exist.

## Configuration
- IMM_PREFIX_EN defined: the prefix state machine and pfx register are built as described in Operation.
- IMM_PREFIX_EN undefined:
  - PREFIX_OP is an ordinary opcode and produces a normal single-field output.
  - prefix_pending is tied 0 and no prefix storage exists.

## Test plan
All scenarios use the default parameters unless stated.
- Signed addi: addi 8'b011_11000 accepted, out_ready=1 → next cycle out_valid=1, imm=16'hFFF8, op_out=3, imm_signed=1.
- Zero-extended load and signed beq: load 8'b000_11111 → imm=16'h001F, imm_signed=0. beq 8'b100_10000 → imm=16'hFFF0.
- Backpressure:
  - out_ready=0 with two instructions (8'b010_00001, 8'b011_00010) offered back-to-back → first held stable with imm=16'h0001, in_ready=0, second not consumed.
  - Raise out_ready → second accepted, imm=16'h0002 appears one cycle later, with no loss or duplication.
- Prefix, IMM_PREFIX_EN defined: 8'b111_10101 then 8'b011_00011 → a single output, imm=16'hFEA3, op_out=3. prefix_pending is 1 between the two accepts.
- Prefix, IMM_PREFIX_EN undefined: the same sequence gives two outputs, op_out=7 with imm=16'h0015, then op_out=3 with imm=16'h0003.
- Reset and flush mid-operation:
  - Prefix pending and out_valid=1, then rst_n pulsed low between clock edges → all outputs 0 immediately.
  - Repeat with flush=1 plus a simultaneous valid input → after the edge out_valid=0, prefix_pending=0, and the input is dropped.
